// File: rtl/onehot_req_arbiter.sv
// Round-robin request arbiter feeding the 4-to-2 encoder: latches request edges,
// presents one pending line as a held one-hot word with enable until acknowledged.
module onehot_req_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         ack,
  input  logic         clr,
  output logic [N-1:0] onehot,
  output logic         en,
  output logic [N-1:0] pending,
  output logic [N-1:0] overflow
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  logic [0:0]    state;
  logic [N-1:0]  req_q;
  logic [LW-1:0] last;
  logic [LW-1:0] gidx;

  logic [N-1:0]  rise;
  logic [N-1:0]  retire;
  logic [N-1:0]  pending_nxt;
  logic [N-1:0]  overflow_nxt;
  logic          sel_found;
  logic [LW-1:0] sel_idx;

  assign rise   = req & ~req_q;
  assign retire = (state == ST_PRESENT && ack) ? onehot : '0;

  // A rise on the bit being retired re-arms it rather than counting as overflow.
  always_comb begin
    pending_nxt  = '0;
    overflow_nxt = '0;
    for (int i = 0; i < N; i++) begin
      if (clr) begin
        pending_nxt[i]  = 1'b0;
        overflow_nxt[i] = 1'b0;
      end else begin
        pending_nxt[i]  = rise[i] | (pending[i] & ~retire[i]);
        overflow_nxt[i] = overflow[i] | (rise[i] & pending[i] & ~retire[i]);
      end
    end
  end

  // Searching downward leaves the nearest set bit after 'last' as the final winner.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = N; k >= 1; k--) begin
      if (pending[(int'(last) + k) % N]) begin
        sel_found = 1'b1;
        sel_idx   = LW'((int'(last) + k) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      req_q    <= '0;
      pending  <= '0;
      overflow <= '0;
      onehot   <= '0;
      en       <= 1'b0;
      last     <= LW'(N - 1);
      gidx     <= '0;
    end else begin
      req_q    <= req;
      pending  <= pending_nxt;
      overflow <= overflow_nxt;
      case (state)
        ST_IDLE: begin
          if (sel_found && !clr) begin
            onehot <= {{(N-1){1'b0}}, 1'b1} << sel_idx;
            en     <= 1'b1;
            gidx   <= sel_idx;
            state  <= ST_PRESENT;
          end
        end
        default: begin
          if (ack) begin
            onehot <= '0;
            en     <= 1'b0;
            last   <= gidx;
            state  <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_req_arbiter.sv
// Scoreboard bench for onehot_req_arbiter: directed scenarios plus random traffic
// against a cycle-level behavioural model of the arbitration rules.
module tb_onehot_req_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       ack;
  logic       clr;
  logic [3:0] onehot;
  logic       en;
  logic [3:0] pending;
  logic [3:0] overflow;

  int errors = 0;
  int checks = 0;

  onehot_req_arbiter #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .clr(clr),
    .onehot(onehot), .en(en), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [3:0] m_reqq, m_pend, m_ov;
  int         m_last, m_gidx;
  bit         m_busy;
  int         expq[$];
  bit         prev_en;
  bit         mon_on;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_reqq = '0; m_pend = '0; m_ov = '0;
    m_last = 3; m_gidx = 0; m_busy = 0;
    expq.delete();
    prev_en = 0;
  endtask

  always @(posedge clk) begin
    logic [3:0] rise, np, nov;
    int ret;
    if (rst_n) begin
      rise = req & ~m_reqq;
      ret = (m_busy && ack) ? m_gidx : -1;
      for (int i = 0; i < 4; i++) begin
        if (clr) begin
          np[i] = 1'b0; nov[i] = 1'b0;
        end else begin
          nov[i] = m_ov[i];
          if (rise[i] && m_pend[i] && i != ret) nov[i] = 1'b1;
          if (rise[i]) np[i] = 1'b1;
          else if (i == ret) np[i] = 1'b0;
          else np[i] = m_pend[i];
        end
      end
      if (m_busy) begin
        if (ack) begin
          m_busy = 0;
          m_last = m_gidx;
        end
      end else if (m_pend != 0 && !clr) begin
        for (int k = 1; k <= 4; k++) begin
          if (m_pend[(m_last + k) % 4]) begin
            m_gidx = (m_last + k) % 4;
            break;
          end
        end
        m_busy = 1;
        expq.push_back(m_gidx);
      end
      m_pend = np; m_ov = nov; m_reqq = req;
    end
  end

  // Monitor: pops an expected grant each time the DUT raises en
  always @(negedge clk) begin
    int e;
    if (rst_n && mon_on) begin
      if (en && !prev_en) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL grant_unexpected: got %b expected none at %0t", onehot, $time);
        end else begin
          e = expq.pop_front();
          chk("grant", onehot, 4'(1 << e));
        end
      end
      prev_en = en;
      chk("pending", pending, m_pend);
      chk("overflow", overflow, m_ov);
      chk("en", {3'b0, en}, {3'b0, m_busy});
      chk("onehot_hold", onehot, m_busy ? 4'(1 << m_gidx) : 4'b0000);
    end
  end

  task automatic drive(input logic [3:0] r, input logic a, input logic c);
    req = r; ack = a; clr = c;
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; ack = 1'b0; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("rst_onehot", onehot, 4'b0000);
    chk("rst_en", {3'b0, en}, 4'b0000);
    chk("rst_pending", pending, 4'b0000);
    chk("rst_overflow", overflow, 4'b0000);
  endtask

  task automatic wait_en(input int budget);
    int n = 0;
    while (!en && n < budget) begin
      drive(4'b0000, 1'b0, 1'b0);
      n++;
    end
    if (!en) begin
      checks++; errors++;
      $display("FAIL wait_en: got en=0 expected en=1 within %0d cycles", budget);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((en || pending != 0) && n < budget) begin
      drive(4'b0000, 1'b1, 1'b0);
      n++;
    end
    drive(4'b0000, 1'b0, 1'b0);
  endtask

  initial begin
    mon_on = 1'b1;
    do_reset();

    // Single request held, then acknowledged
    drive(4'b0001, 1'b0, 1'b0);
    chk("t1_pending", pending, 4'b0001);
    chk("t1_en_early", {3'b0, en}, 4'b0000);
    drive(4'b0000, 1'b0, 1'b0);
    chk("t1_onehot", onehot, 4'b0001);
    chk("t1_en", {3'b0, en}, 4'b0001);
    repeat (5) drive(4'b0000, 1'b0, 1'b0);
    chk("t1_hold", onehot, 4'b0001);
    drive(4'b0000, 1'b1, 1'b0);
    chk("t1_done_onehot", onehot, 4'b0000);
    chk("t1_done_pending", pending, 4'b0000);

    // Four simultaneous edges, continuous ack
    drive(4'b1111, 1'b1, 1'b0);
    repeat (10) drive(4'b0000, 1'b1, 1'b0);
    chk("t2_pending", pending, 4'b0000);
    chk("t2_queue", 4'(expq.size()), 4'd0);

    // Round robin: serve line 1, then pending 1011 goes to line 3
    do_reset();
    drive(4'b0010, 1'b0, 1'b0);
    wait_en(4);
    chk("t3_first", onehot, 4'b0010);
    drive(4'b0000, 1'b1, 1'b0);
    drive(4'b1011, 1'b0, 1'b0);
    drive(4'b0000, 1'b0, 1'b0);
    chk("t3_rr", onehot, 4'b1000);
    drain(20);

    // Overflow and clear while presenting
    drive(4'b0100, 1'b0, 1'b0);
    wait_en(4);
    drive(4'b0100, 1'b0, 1'b0);
    drive(4'b0000, 1'b0, 1'b0);
    chk("t4_ov", overflow, 4'b0100);
    chk("t4_pend", pending, 4'b0100);
    drive(4'b0000, 1'b0, 1'b1);
    chk("t4_clr_ov", overflow, 4'b0000);
    chk("t4_clr_pend", pending, 4'b0000);
    chk("t4_keep", onehot, 4'b0100);
    drive(4'b0000, 1'b1, 1'b0);
    chk("t4_ack", onehot, 4'b0000);
    drain(10);

    // Retire and re-rise on line 3 in the same cycle
    drive(4'b1000, 1'b0, 1'b0);
    drive(4'b0000, 1'b0, 1'b0);
    wait_en(4);
    drive(4'b1000, 1'b1, 1'b0);
    chk("t5_pend", pending, 4'b1000);
    chk("t5_ov", overflow, 4'b0000);
    drive(4'b0000, 1'b0, 1'b0);
    chk("t5_regrant", onehot, 4'b1000);
    drain(10);

    // Asynchronous reset in the middle of a grant
    drive(4'b0010, 1'b0, 1'b0);
    wait_en(4);
    chk("t6_pre", onehot, 4'b0010);
    rst_n = 1'b0;
    #1;
    chk("t6_async_en", {3'b0, en}, 4'b0000);
    chk("t6_async_onehot", onehot, 4'b0000);
    do_reset();
    repeat (4) drive(4'b0000, 1'b0, 1'b0);
    chk("t6_idle", onehot, 4'b0000);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 19) == 0));
    end
    drain(40);
    chk("rand_queue", 4'(expq.size()), 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
